prbs7_checker: RTL and testbench
================================

PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 32: consecutive matching bits required to declare lock.
REQ-002 SHALL have parameter LOS_ERR, default 8: errors within one LOS window that force loss of lock.
REQ-003 SHALL have parameter LOS_WIN, default 64: LOS window length in checked bits.
REQ-004 SHALL have parameter CNT_W, default 16: width of err_cnt.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port en, input, 1: din is valid on this edge; when 0, all state and counters hold.
REQ-008 SHALL have port din, input, 1: serial PRBS7 bit from the 32:1 serializer output.
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of err_cnt and bit_cnt.
REQ-010 SHALL have port locked, output, 1: checker is aligned to the PRBS7 stream.
REQ-011 SHALL have port err_pulse, output, 1: one-cycle strobe per bit error detected while locked.
REQ-012 SHALL have port err_cnt, output, CNT_W: saturating count of bit errors while locked.
REQ-013 SHALL have port bit_cnt, output, 32: saturating count of bits checked while locked.

Function
REQ-014 SHALL use polynomial x^7+x^6+1; predicted bit = s[6] XOR s[5] of the 7-bit state s, shifted in at s[0].
REQ-015 SHALL implement a three-state FSM: ACQUIRE, VERIFY, LOCKED; only edges with en=1 advance it.
REQ-016 ACQUIRE: shift din into s for 7 bits (fill counter 0..6); after the 7th bit go to VERIFY if s is nonzero, else restart fill.
REQ-017 VERIFY: compare din to predicted bit and shift din into s; on a mismatch, return to ACQUIRE with the fill counter at 0; after LOCK_CNT consecutive matches, go to LOCKED.
REQ-018 LOCKED: s SHALL advance on its own predicted bit, not din, so input errors do not propagate; each mismatch is one error.
REQ-019 locked SHALL be registered, high from the edge that enters LOCKED and low from the edge that leaves it.
REQ-020 With en held high, locked SHALL rise on the edge sampling bit number 7+LOCK_CNT (1-based) after acquisition starts.
REQ-021 err_pulse, err_cnt and bit_cnt SHALL update on the edge that samples the bit (registered, latency 1 edge).
REQ-022 Each checked bit in LOCKED SHALL add 1 to bit_cnt; bit_cnt SHALL saturate at 0xFFFFFFFF.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 LOS: a window counter SHALL count LOCKED bits modulo LOS_WIN, and per-window errors SHALL reset at each window boundary.
REQ-025 If per-window errors reach LOS_ERR, the FSM SHALL go to ACQUIRE on that edge; err_cnt and bit_cnt SHALL hold their values.
REQ-026 An error on the window's last bit SHALL count toward the ending window, before that window's count resets.
REQ-027 If clr_cnt and an error occur on the same edge, clr_cnt SHALL win: err_cnt=0 and bit_cnt=0, while err_pulse still asserts.
REQ-028 clr_cnt SHALL NOT affect FSM state, s, or the LOS counters.
REQ-029 err_pulse SHALL be 0 in ACQUIRE and VERIFY; mismatches there SHALL NOT be counted.

Reset
REQ-030 With rst_n=0 at an edge, the block SHALL load state ACQUIRE, s=0, fill/match/window counters 0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0, regardless of en.
REQ-031 Reset mid-LOCKED SHALL take effect on that same edge, with no residual error strobe.

Structure
REQ-032 Package prbs_pkg SHALL hold PRBS_ORDER=7, tap positions (6,5), and the FSM state enum, shared with the PRBS7 generator.
REQ-033 One sub-module, prbs7_predictor, SHALL contain the 7-bit state register, load-from-din/self-advance select, and predicted-bit output.

Verification
REQ-034 Clean PRBS7 stream, seed 7'h7F, en=1 -> locked rises on edge 39; err_cnt=0 and bit_cnt=1000 after 1000 further bits.
REQ-035 One flipped bit, 100 bits after lock -> single err_pulse, err_cnt=1, locked stays 1, following bits error-free.
REQ-036 8 flipped bits within one 64-bit window -> locked falls on the 8th error edge, then rises again 39 clean bits later; err_cnt=8.
REQ-037 din held 0 for 500 cycles after reset -> locked never asserts, err_cnt=0.
REQ-038 CNT_W=4, 20 single errors spaced 100 bits apart -> err_cnt=15 (saturated), locked stays 1; clr_cnt coincident with the next error -> err_cnt=0, err_pulse=1.
REQ-039 rst_n=0 for one edge while locked with err_cnt=5 -> next cycle locked=0, err_cnt=0, bit_cnt=0, err_pulse=0.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS7 constants, tap positions, lock FSM state type
package prbs_pkg;

    localparam int PRBS_ORDER = 7;
    localparam int TAP_A      = 6;
    localparam int TAP_B      = 5;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_LOCKED  = 2'd2
    } prbs_state_t;

    // Next PRBS7 bit (x^7 + x^6 + 1) from the current 7-bit state.
    function automatic logic prbs_pred(input logic [PRBS_ORDER-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs7_predictor.sv
// rtl/prbs7_predictor.sv - PRBS7 state register with din-load / self-advance select
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset (state -> 0)
//   shift_en      : advance the state register this edge
//   use_din       : 1 = shift din into the state, 0 = shift the predicted bit
//   din           : serial input bit
//   pred          : predicted next bit from the current state
//   fill_nonzero  : state after shifting din in would be nonzero
module prbs7_predictor
    import prbs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic use_din,
    input  logic din,
    output logic pred,
    output logic fill_nonzero
);

    logic [PRBS_ORDER-1:0] state;

    assign pred         = prbs_pred(state);
    assign fill_nonzero = ({state[PRBS_ORDER-2:0], din} != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
        end else if (shift_en) begin
            // Self-advancing while locked keeps corrupted input bits out of the state.
            state <= {state[PRBS_ORDER-2:0], (use_din ? din : pred)};
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - PRBS7 serial checker with lock FSM, error/bit counters and loss-of-sync
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : din valid this edge; when low all state and counters hold
//   din        : serial PRBS7 bit
//   clr_cnt    : synchronous clear of err_cnt and bit_cnt
//   locked     : registered lock indication
//   err_pulse  : one-cycle strobe per bit error while locked
//   err_cnt    : saturating error count while locked
//   bit_cnt    : saturating checked-bit count while locked
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int LOS_ERR  = 8,
    parameter int LOS_WIN  = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      bit_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = (LOS_WIN > 1) ? $clog2(LOS_WIN) : 1;
    localparam int LOSE_W  = $clog2(LOS_ERR + 1);

    prbs_state_t        state, state_nxt;
    logic [2:0]         fill_cnt, fill_nxt;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic [WIN_W-1:0]   win_cnt, win_nxt;
    logic [LOSE_W-1:0]  win_err, win_err_nxt, win_err_inc;
    logic               pred_bit;
    logic               fill_nonzero;
    logic               mismatch;
    logic               use_din;

    assign use_din = (state != ST_LOCKED);

    prbs7_predictor u_pred (
        .clk          (clk),
        .rst_n        (rst_n),
        .shift_en     (en),
        .use_din      (use_din),
        .din          (din),
        .pred         (pred_bit),
        .fill_nonzero (fill_nonzero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fill_nxt    = fill_cnt;
        match_nxt   = match_cnt;
        win_nxt     = win_cnt;
        win_err_nxt = win_err;
        win_err_inc = '0;
        mismatch    = 1'b0;
        if (en) begin
            case (state)
                ST_ACQUIRE: begin
                    if (fill_cnt == 3'(PRBS_ORDER - 1)) begin
                        fill_nxt = '0;
                        // An all-zero state is the PRBS lock-up state; refill instead.
                        if (fill_nonzero) begin
                            state_nxt = ST_VERIFY;
                            match_nxt = '0;
                        end
                    end else begin
                        fill_nxt = fill_cnt + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    if (din != pred_bit) begin
                        state_nxt = ST_ACQUIRE;
                        fill_nxt  = '0;
                        match_nxt = '0;
                    end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        state_nxt   = ST_LOCKED;
                        match_nxt   = '0;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    mismatch    = (din != pred_bit);
                    win_err_inc = win_err + LOSE_W'(mismatch);
                    // The error on a window's last bit still counts toward that window.
                    if (mismatch && (win_err_inc >= LOSE_W'(LOS_ERR))) begin
                        state_nxt   = ST_ACQUIRE;
                        fill_nxt    = '0;
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else if (win_cnt == WIN_W'(LOS_WIN - 1)) begin
                        win_nxt     = '0;
                        win_err_nxt = '0;
                    end else begin
                        win_nxt     = win_cnt + WIN_W'(1);
                        win_err_nxt = win_err_inc;
                    end
                end
                default: begin
                    state_nxt = ST_ACQUIRE;
                    fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            win_cnt   <= win_nxt;
            win_err   <= win_err_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= mismatch;
            // Clear beats a coincident error; err_pulse still reports it.
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (en && (state == ST_LOCKED) && (bit_cnt != '1)) begin
                bit_cnt <= bit_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - directed self-checking bench for prbs7_checker
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst_n, en, din, clr_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;
    logic [31:0] bit_cnt4;

    int   checks = 0;
    int   errors = 0;
    logic [6:0] g;
    int   lbits;
    bit   in_lock;
    int   pulse_cnt;
    int   p0;
    bit   lock_seen;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    prbs7_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4),
        .bit_cnt   (bit_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the next reference PRBS7 bit (optionally inverted) for one edge.
    task automatic send(input logic flip);
        logic b;
        b   = g[6] ^ g[5];
        g   = {g[5:0], b};
        din = b ^ flip;
        if (in_lock) lbits++;
        @(posedge clk);
        #1;
        if (err_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic align_window();
        while ((lbits % 64) != 0) send(1'b0);
    endtask

    // Acquisition takes 7 fill bits plus 32 matches: locked on the 39th bit.
    task automatic relock(input string tag);
        send_clean(38);
        chk({tag, "_pre"}, locked, 1'b0);
        send(1'b0);
        chk(tag, locked, 1'b1);
        in_lock = 1'b1;
        lbits   = 0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        g = 7'h7F; in_lock = 1'b0; lbits = 0; pulse_cnt = 0; lock_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 1'b0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_bit_cnt", bit_cnt, 32'd0);

        // Constant zero input never leaves acquisition.
        rst_n = 1'b1; en = 1'b1; din = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (locked === 1'b1) lock_seen = 1'b1;
        end
        chk("zeros_no_lock", lock_seen, 1'b0);
        chk("zeros_err_cnt", err_cnt, 16'd0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean stream from seed 7F.
        g = 7'h7F;
        relock("lock_edge39");
        chk("lock_bit_cnt", bit_cnt, 32'd0);
        p0 = pulse_cnt;
        send_clean(1000);
        chk("clean_err_cnt", err_cnt, 16'd0);
        chk("clean_bit_cnt", bit_cnt, 32'd1000);
        chk("clean_pulses", pulse_cnt - p0, 0);

        // Single flipped bit.
        send_clean(99);
        send(1'b1);
        chk("single_pulse", err_pulse, 1'b1);
        chk("single_err_cnt", err_cnt, 16'd1);
        chk("single_locked", locked, 1'b1);
        chk("single_bit_cnt", bit_cnt, 32'd1100);
        p0 = pulse_cnt;
        send(1'b0);
        chk("single_pulse_off", err_pulse, 1'b0);
        send_clean(200);
        chk("single_no_propagate", pulse_cnt - p0, 0);
        chk("single_err_hold", err_cnt, 16'd1);

        // Eight errors in one window force loss of lock.
        align_window();
        clr_cnt = 1'b1;
        send(1'b0);
        clr_cnt = 1'b0;
        chk("clr_err_cnt", err_cnt, 16'd0);
        chk("clr_bit_cnt", bit_cnt, 32'd0);
        for (int i = 1; i < 16; i++) begin
            send(1'(i % 2));
            if (i == 13) chk("los_7_errs_locked", locked, 1'b1);
        end
        chk("los_locked", locked, 1'b0);
        chk("los_pulse", err_pulse, 1'b1);
        chk("los_err_cnt", err_cnt, 16'd8);
        chk("los_bit_cnt", bit_cnt, 32'd15);
        in_lock = 1'b0;
        p0 = pulse_cnt;
        relock("los_relock39");
        chk("relock_err_hold", err_cnt, 16'd8);
        chk("relock_bit_hold", bit_cnt, 32'd15);
        chk("relock_no_pulses", pulse_cnt - p0, 0);

        // Four errors each side of a window boundary stay locked.
        send_clean(60);
        repeat (8) send(1'b1);
        chk("straddle_locked", locked, 1'b1);
        chk("straddle_err_cnt", err_cnt, 16'd16);

        // Eighth error on the window's last bit still trips loss of lock.
        align_window();
        send_clean(56);
        for (int i = 0; i < 8; i++) begin
            send(1'b1);
            if (i == 6) chk("lastbit_7_locked", locked, 1'b1);
        end
        chk("lastbit_los", locked, 1'b0);
        chk("lastbit_err_cnt", err_cnt, 16'd24);
        in_lock = 1'b0;
        relock("lastbit_relock");

        // Saturation with CNT_W=4, then clear coincident with an error.
        clr_cnt = 1'b1;
        send(1'b0);
        clr_cnt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send_clean(99);
            send(1'b1);
        end
        chk("sat_err_cnt4", err_cnt4, 4'd15);
        chk("sat_err_cnt16", err_cnt, 16'd20);
        chk("sat_locked4", locked4, 1'b1);
        chk("sat_locked", locked, 1'b1);
        send_clean(99);
        clr_cnt = 1'b1;
        send(1'b1);
        clr_cnt = 1'b0;
        chk("clrerr_pulse4", err_pulse4, 1'b1);
        chk("clrerr_err_cnt4", err_cnt4, 4'd0);
        chk("clrerr_bit_cnt4", bit_cnt4, 32'd0);
        chk("clrerr_err_cnt", err_cnt, 16'd0);

        // Reset while locked with a pending error.
        for (int k = 0; k < 5; k++) begin
            send_clean(20);
            send(1'b1);
        end
        chk("pre_rst_err_cnt", err_cnt, 16'd5);
        rst_n = 1'b0;
        send(1'b1);
        rst_n = 1'b1;
        in_lock = 1'b0;
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_err_cnt", err_cnt, 16'd0);
        chk("midrst_bit_cnt", bit_cnt, 32'd0);
        chk("midrst_pulse", err_pulse, 1'b0);

        // A mismatch during verify restarts acquisition without counting.
        p0 = pulse_cnt;
        send_clean(17);
        send(1'b1);
        relock("verify_restart_lock");
        chk("verify_no_pulses", pulse_cnt - p0, 0);
        chk("verify_err_cnt", err_cnt, 16'd0);

        // en low holds everything regardless of din.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("hold_bit_cnt", bit_cnt, 32'd0);
        chk("hold_locked", locked, 1'b1);
        chk("hold_pulse", err_pulse, 1'b0);
        en = 1'b1;
        send_clean(10);
        chk("resume_bit_cnt", bit_cnt, 32'd10);
        chk("resume_err_cnt", err_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
